product_bcd_converter: RTL and testbench
========================================

Name: product_bcd_converter

Overview:
- Downstream stage of the 8x8 shift-add multiplier datapath.
- Consumes the 16-bit product, presented as high byte plus low byte, and converts it to sign-magnitude packed BCD for decimal display.
- Sequential double-dabble: one shift per clock, with start/busy/done handshake.
- Outputs are registered and held stable between conversions, so the display never shows intermediate values.

Parameters:
- WIDTH, 16: product width in bits; must be even, and product_hi/product_lo are each WIDTH/2.
- DIGITS, 5: BCD digit count; must be large enough to hold 2^WIDTH-1 (5 for 16).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  request conversion; sampled only in IDLE.
- signed_mode  in  1  1 = treat operand as two's complement; 0 = unsigned.
- product_hi  in  WIDTH/2  upper byte of the product (multiplier A register).
- product_lo  in  WIDTH/2  lower byte of the product (multiplier B register).
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the outputs update.
- valid  out  1  high once any conversion has completed since reset.
- negative  out  1  sign of the last converted value.
- bcd  out  4*DIGITS  packed BCD magnitude; digit 0 in bits [3:0].
- digit_en  out  DIGITS  leading-zero blanking mask; bit i = 1 means display digit i.

Behaviour:
- Reset (takes precedence over everything, including mid-conversion):
  - State goes to IDLE and the working registers clear.
  - busy=0, done=0, valid=0, negative=0, bcd=0, digit_en=0.
  - Any in-flight conversion is discarded and no done is produced.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - busy=0.
  - If start=1 at an edge:
    - Capture operand = {product_hi, product_lo}.
    - neg_w = signed_mode & operand[WIDTH-1].
    - mag_w = neg_w ? (~operand + 1) : operand, computed in WIDTH bits unsigned, so 0x8000 gives 32768 with no overflow.
    - Clear the BCD shift register, set count=0, go to CONVERT.
- CONVERT:
  - busy=1.
  - Each edge: every BCD digit >=5 gets +3, then {bcd_w, mag_w} shifts left by 1.
  - count increments; after the WIDTH-th shift (count==WIDTH-1) go to DONE.
  - start is ignored.
- DONE:
  - busy=1.
  - Next edge: bcd <= bcd_w, negative <= neg_w, digit_en <= blanking(bcd_w), valid <= 1, done <= 1, go to IDLE.
  - done is 0 in all other cycles.
- Latency:
  - Start sampled at edge e1.
  - Shifts occur at edges e2..e(WIDTH+1).
  - Outputs update and done rises at edge e(WIDTH+2), i.e. 18 clocks for WIDTH=16.
- Back-to-back: start high in the same cycle as done is accepted, since the state is already IDLE.
- Operand stability: product_hi/product_lo/signed_mode may change freely after the capture edge.
- Blanking:
  - digit_en[0] is always 1.
  - digit_en[i] = 1 iff any of digits i..DIGITS-1 is non-zero.
- Zero result: negative=0 always, because magnitude 0 implies neg_w=0 only when the input is 0.
- Outputs hold their values indefinitely until the next DONE or Reset.

Decomposition:
- Package product_bcd_pkg holds:
  - state enum {IDLE, CONVERT, DONE}.
  - Default constants for WIDTH and DIGITS.
  - Count width $clog2(WIDTH).
- Sub-module bcd_digit_adjust: combinational, 4-bit in/out, applies add-3 when input >=5. Instantiated DIGITS times in a generate loop.
- Blanking logic and the FSM stay in the top module.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, valid=0.
- signed_mode=0, hi=0xFF, lo=0xFF, start pulse -> done exactly 18 clocks later; bcd=0x65535, negative=0, digit_en=11111, valid=1.
- signed_mode=1, hi=0xFF, lo=0xFF -> bcd=0x00001, negative=1, digit_en=00001.
- signed_mode=1, hi=0x80, lo=0x00 -> bcd=0x32768, negative=1.
- signed_mode=1, hi=0x00, lo=0x00 -> bcd=0x00000, negative=0, digit_en=00001.
- Busy and reset handling:
  - Start 0x00C8 (200), unsigned, then pulse start with 0x0001 during CONVERT -> ignored; result bcd=0x00200, digit_en=00111.
  - Then start 0x3039, assert Reset at shift 7 -> no done, all outputs 0.
  - Restart 0x3039 -> bcd=0x12345.

Source files
------------

// File: rtl/product_bcd_pkg.sv
// Shared types and default sizing for the product-to-BCD converter.
package product_bcd_pkg;

   localparam int WIDTH_DEF  = 16;
   localparam int DIGITS_DEF = 5;
   localparam int CNT_W_DEF  = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Bundle of the converter's request and result signals.
//
// Handshake: the master raises start while busy is low; the request is
// taken on that rising edge and busy rises on it.  start is ignored while
// busy is high.  done pulses for exactly one cycle on the edge that
// updates valid/negative/bcd/digit_en; the state is already IDLE during
// that cycle, so a start held high in it is accepted.  Result signals
// hold their value between done pulses.
interface product_bcd_converter_if
   import product_bcd_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
);

   logic                  start;
   logic                  signed_mode;
   logic [WIDTH/2-1:0]    product_hi;
   logic [WIDTH/2-1:0]    product_lo;
   logic                  busy;
   logic                  done;
   logic                  valid;
   logic                  negative;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     digit_en;
   state_t                state;

   modport master (
      output start, signed_mode, product_hi, product_lo,
      input  busy, done, valid, negative, bcd, digit_en, state
   );

   modport slave (
      input  start, signed_mode, product_hi, product_lo,
      output busy, done, valid, negative, bcd, digit_en, state
   );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   // Add-3 correction applied before each shift.
   always_comb begin
      adjusted = digit;
      if (digit >= 4'd5) begin
         adjusted = digit + 4'd3;
      end
   end

endmodule

// File: rtl/product_bcd_converter.sv
// Converts the multiplier's 16-bit product into sign-magnitude packed BCD with
// a sequential double-dabble (one shift per clock).  Results are registered and
// only change on the done cycle, so a display never sees partial values.
module product_bcd_converter
   import product_bcd_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                     Clk,
   input  logic                     Reset,
   product_bcd_converter_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     mag_q;
   logic                 neg_q;
   logic [4*DIGITS-1:0]  work_q;
   logic [4*DIGITS-1:0]  work_adj;

   logic [WIDTH-1:0]     operand;
   logic                 operand_neg;
   logic [WIDTH-1:0]     operand_mag;

   logic [4*DIGITS-1:0]  bcd_q;
   logic                 negative_q;
   logic [DIGITS-1:0]    digit_en_q;
   logic [DIGITS-1:0]    blank;
   logic                 valid_q;
   logic                 done_q;

   // Sign/magnitude split of the incoming product; the negation is done in
   // WIDTH bits unsigned so the most negative value maps to 2^(WIDTH-1).
   always_comb begin
      operand     = {bus.product_hi, bus.product_lo};
      operand_neg = bus.signed_mode & operand[WIDTH-1];
      operand_mag = operand_neg ? (~operand + 1'b1) : operand;
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit    (work_q[4*g +: 4]),
         .adjusted (work_adj[4*g +: 4])
      );
   end

   // Leading-zero blanking: a digit is shown if it or any higher digit is
   // non-zero; the units digit is always shown so zero reads as "0".
   always_comb begin
      logic any_nz;
      any_nz = 1'b0;
      blank  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         any_nz   = any_nz | (work_q[4*i +: 4] != 4'd0);
         blank[i] = any_nz;
      end
      blank[0] = 1'b1;
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = CONVERT;
         CONVERT: if (cnt_q == LAST_SHIFT) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Working registers and result registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q      <= '0;
         mag_q      <= '0;
         neg_q      <= 1'b0;
         work_q     <= '0;
         bcd_q      <= '0;
         negative_q <= 1'b0;
         digit_en_q <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  mag_q  <= operand_mag;
                  neg_q  <= operand_neg;
                  work_q <= '0;
                  cnt_q  <= '0;
               end
            end
            CONVERT: begin
               {work_q, mag_q} <= {work_adj[4*DIGITS-2:0], mag_q, 1'b0};
               cnt_q           <= cnt_q + 1'b1;
            end
            DONE: begin
               bcd_q      <= work_q;
               negative_q <= neg_q;
               digit_en_q <= blank;
               valid_q    <= 1'b1;
               done_q     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.valid    = valid_q;
   assign bus.negative = negative_q;
   assign bus.bcd      = bcd_q;
   assign bus.digit_en = digit_en_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Bench for product_bcd_converter: scenario tasks compared against a decimal
// reference model computed with plain integer arithmetic.
module tb_product_bcd_converter;
   import product_bcd_pkg::*;

   logic Clk;
   logic Reset;
   int   checks;
   int   failures;

   product_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus_if ();

   product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus_if)
   );

   // Clock and reset.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: sign-magnitude decimal value of {hi,lo}.
   function automatic void model(input bit sm, input logic [7:0] hi, input logic [7:0] lo,
                                 output bit neg, output logic [19:0] bcd, output logic [4:0] en);
      int v;
      int mag;
      int rem;
      v   = int'({hi, lo});
      neg = sm && (v >= 32768);
      mag = neg ? (65536 - v) : v;
      rem = mag;
      bcd = '0;
      for (int i = 0; i < 5; i++) begin
         bcd[4*i +: 4] = 4'(rem % 10);
         rem           = rem / 10;
      end
      for (int i = 0; i < 5; i++) begin
         en[i] = (i == 0) || (mag >= 10 ** i);
      end
   endfunction

   // Driver: one start pulse, then wait for done. lat counts the start edge
   // as 1; lat = 0 means no done within the budget.
   task automatic run_convert(input bit sm, input logic [7:0] hi, input logic [7:0] lo,
                              output int lat);
      @(negedge Clk);
      bus_if.signed_mode = sm;
      bus_if.product_hi  = hi;
      bus_if.product_lo  = lo;
      bus_if.start       = 1'b1;
      @(posedge Clk);
      #1;
      bus_if.start       = 1'b0;
      bus_if.signed_mode = 1'($urandom_range(0, 1));
      bus_if.product_hi  = 8'($urandom_range(0, 255));
      bus_if.product_lo  = 8'($urandom_range(0, 255));
      lat = 0;
      for (int k = 2; k <= 40; k++) begin
         @(posedge Clk);
         #1;
         if (bus_if.done === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bus_if.start = 1'b0;
      bus_if.signed_mode = 1'b0;
      bus_if.product_hi = '0;
      bus_if.product_lo = '0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
      checks++;
      if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
      checks++;
      if (bus_if.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
      checks++;
      if (bus_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_if.valid); end
      checks++;
      if (bus_if.negative !== 1'b0) begin failures++; $display("FAIL reset_negative got=%b exp=0", bus_if.negative); end
      checks++;
      if (bus_if.bcd !== 20'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=00000", bus_if.bcd); end
      checks++;
      if (bus_if.digit_en !== 5'b0) begin failures++; $display("FAIL reset_digit_en got=%b exp=00000", bus_if.digit_en); end
      checks++;
      if (bus_if.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus_if.state, IDLE); end
   endtask

   task automatic test_unsigned_max();
      int lat;
      run_convert(1'b0, 8'hFF, 8'hFF, lat);
      checks++;
      if (lat != 18) begin failures++; $display("FAIL umax_latency got=%0d exp=18", lat); end
      checks++;
      if (bus_if.bcd !== 20'h65535) begin failures++; $display("FAIL umax_bcd got=%h exp=65535", bus_if.bcd); end
      checks++;
      if (bus_if.negative !== 1'b0) begin failures++; $display("FAIL umax_negative got=%b exp=0", bus_if.negative); end
      checks++;
      if (bus_if.digit_en !== 5'b11111) begin failures++; $display("FAIL umax_digit_en got=%b exp=11111", bus_if.digit_en); end
      checks++;
      if (bus_if.valid !== 1'b1) begin failures++; $display("FAIL umax_valid got=%b exp=1", bus_if.valid); end
      checks++;
      if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL umax_busy_at_done got=%b exp=0", bus_if.busy); end
      @(posedge Clk);
      #1;
      checks++;
      if (bus_if.done !== 1'b0) begin failures++; $display("FAIL umax_done_pulse got=%b exp=0", bus_if.done); end
      repeat (4) @(posedge Clk);
      #1;
      checks++;
      if (bus_if.bcd !== 20'h65535) begin failures++; $display("FAIL umax_hold got=%h exp=65535", bus_if.bcd); end
   endtask

   task automatic test_signed_edges();
      logic [15:0] ops [3];
      bit          neg;
      logic [19:0] bcd;
      logic [4:0]  en;
      int          lat;
      ops[0] = 16'hFFFF;
      ops[1] = 16'h8000;
      ops[2] = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         model(1'b1, ops[i][15:8], ops[i][7:0], neg, bcd, en);
         run_convert(1'b1, ops[i][15:8], ops[i][7:0], lat);
         checks++;
         if (lat != 18) begin failures++; $display("FAIL signed_latency op=%h got=%0d exp=18", ops[i], lat); end
         checks++;
         if (bus_if.bcd !== bcd) begin failures++; $display("FAIL signed_bcd op=%h got=%h exp=%h", ops[i], bus_if.bcd, bcd); end
         checks++;
         if (bus_if.negative !== neg) begin failures++; $display("FAIL signed_negative op=%h got=%b exp=%b", ops[i], bus_if.negative, neg); end
         checks++;
         if (bus_if.digit_en !== en) begin failures++; $display("FAIL signed_digit_en op=%h got=%b exp=%b", ops[i], bus_if.digit_en, en); end
      end
   endtask

   task automatic test_random();
      bit          sm;
      logic [7:0]  hi, lo;
      bit          neg;
      logic [19:0] bcd;
      logic [4:0]  en;
      int          lat;
      for (int i = 0; i < 25; i++) begin
         sm = 1'($urandom_range(0, 1));
         hi = 8'($urandom_range(0, 255));
         lo = 8'($urandom_range(0, 255));
         model(sm, hi, lo, neg, bcd, en);
         run_convert(sm, hi, lo, lat);
         checks++;
         if (lat != 18 || bus_if.bcd !== bcd || bus_if.negative !== neg || bus_if.digit_en !== en) begin
            failures++;
            $display("FAIL random op=%h%h sm=%b got lat=%0d bcd=%h neg=%b en=%b exp lat=18 bcd=%h neg=%b en=%b",
                     hi, lo, sm, lat, bus_if.bcd, bus_if.negative, bus_if.digit_en, bcd, neg, en);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      @(negedge Clk);
      bus_if.signed_mode = 1'b0;
      bus_if.product_hi  = 8'h00;
      bus_if.product_lo  = 8'hC8;
      bus_if.start       = 1'b1;
      @(posedge Clk);
      #1 bus_if.start = 1'b0;
      lat = 0;
      for (int k = 2; k <= 40; k++) begin
         @(negedge Clk);
         if (k == 6) begin
            checks++;
            if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL busy_mid_convert got=%b exp=1", bus_if.busy); end
            bus_if.product_hi = 8'h00;
            bus_if.product_lo = 8'h01;
            bus_if.start      = 1'b1;
         end else begin
            bus_if.start = 1'b0;
         end
         @(posedge Clk);
         #1;
         if (bus_if.done === 1'b1) begin
            lat = k;
            break;
         end
      end
      bus_if.start = 1'b0;
      checks++;
      if (lat != 18) begin failures++; $display("FAIL ignore_latency got=%0d exp=18", lat); end
      checks++;
      if (bus_if.bcd !== 20'h00200) begin failures++; $display("FAIL ignore_bcd got=%h exp=00200", bus_if.bcd); end
      checks++;
      if (bus_if.digit_en !== 5'b00111) begin failures++; $display("FAIL ignore_digit_en got=%b exp=00111", bus_if.digit_en); end
      repeat (25) @(posedge Clk);
      #1;
      checks++;
      if (bus_if.bcd !== 20'h00200 || bus_if.busy !== 1'b0) begin
         failures++;
         $display("FAIL ignore_no_second got bcd=%h busy=%b exp bcd=00200 busy=0", bus_if.bcd, bus_if.busy);
      end
   endtask

   task automatic test_reset_mid();
      int saw_done;
      int lat;
      @(negedge Clk);
      bus_if.signed_mode = 1'b0;
      bus_if.product_hi  = 8'h30;
      bus_if.product_lo  = 8'h39;
      bus_if.start       = 1'b1;
      @(posedge Clk);
      #1 bus_if.start = 1'b0;
      repeat (6) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      saw_done = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge Clk);
         #1;
         if (bus_if.done === 1'b1) saw_done++;
      end
      checks++;
      if (saw_done != 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", saw_done); end
      checks++;
      if (bus_if.valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.negative !== 1'b0 ||
          bus_if.bcd !== 20'h0 || bus_if.digit_en !== 5'b0) begin
         failures++;
         $display("FAIL reset_mid_outputs got valid=%b busy=%b neg=%b bcd=%h en=%b exp all zero",
                  bus_if.valid, bus_if.busy, bus_if.negative, bus_if.bcd, bus_if.digit_en);
      end
      run_convert(1'b0, 8'h30, 8'h39, lat);
      checks++;
      if (lat != 18 || bus_if.bcd !== 20'h12345 || bus_if.digit_en !== 5'b11111) begin
         failures++;
         $display("FAIL restart got lat=%0d bcd=%h en=%b exp lat=18 bcd=12345 en=11111",
                  lat, bus_if.bcd, bus_if.digit_en);
      end
   endtask

   task automatic test_back_to_back();
      bit          neg;
      logic [19:0] bcd;
      logic [4:0]  en;
      logic [7:0]  hi, lo;
      int          lat;
      run_convert(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat);
      // done is visible now; present the next request in this same cycle.
      hi = 8'($urandom_range(128, 255));
      lo = 8'($urandom_range(0, 255));
      model(1'b1, hi, lo, neg, bcd, en);
      bus_if.signed_mode = 1'b1;
      bus_if.product_hi  = hi;
      bus_if.product_lo  = lo;
      bus_if.start       = 1'b1;
      @(posedge Clk);
      #1;
      bus_if.start = 1'b0;
      checks++;
      if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", bus_if.busy); end
      lat = 0;
      for (int k = 2; k <= 40; k++) begin
         @(posedge Clk);
         #1;
         if (bus_if.done === 1'b1) begin
            lat = k;
            break;
         end
      end
      checks++;
      if (lat != 18 || bus_if.bcd !== bcd || bus_if.negative !== neg || bus_if.digit_en !== en) begin
         failures++;
         $display("FAIL b2b_result op=%h%h got lat=%0d bcd=%h neg=%b en=%b exp lat=18 bcd=%h neg=%b en=%b",
                  hi, lo, lat, bus_if.bcd, bus_if.negative, bus_if.digit_en, bcd, neg, en);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_unsigned_max();
      test_signed_edges();
      test_random();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
